// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end.
// Contents: opcodes, ALU ctrl codes, FSM states and the latency-class helper.
package alu_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SLL    = 5'd1;
    localparam logic [4:0] ALU_SLT    = 5'd2;
    localparam logic [4:0] ALU_SLTU   = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SRL    = 5'd5;
    localparam logic [4:0] ALU_OR     = 5'd6;
    localparam logic [4:0] ALU_AND    = 5'd7;
    localparam logic [4:0] ALU_MUL    = 5'd8;
    localparam logic [4:0] ALU_MULH   = 5'd9;
    localparam logic [4:0] ALU_MULHSU = 5'd10;
    localparam logic [4:0] ALU_MULHU  = 5'd11;
    localparam logic [4:0] ALU_DIV    = 5'd12;
    localparam logic [4:0] ALU_DIVU   = 5'd13;
    localparam logic [4:0] ALU_REM    = 5'd14;
    localparam logic [4:0] ALU_REMU   = 5'd15;
    localparam logic [4:0] ALU_SUB    = 5'd16;
    localparam logic [4:0] ALU_SRA    = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LAT_CLASS_I = 2'd0,
        LAT_CLASS_M = 2'd1,
        LAT_CLASS_D = 2'd2
    } lat_class_t;

    // ctrl[3] separates RV32I from M-extension ops; ctrl[2] then separates mul from div/rem
    function automatic lat_class_t lat_class_sel(input logic [4:0] ctrl);
        if (!ctrl[3]) begin
            return LAT_CLASS_I;
        end else if (!ctrl[2]) begin
            return LAT_CLASS_M;
        end else begin
            return LAT_CLASS_D;
        end
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of an RV32I/M R/I-type ALU instruction into the
// ALU ctrl code, operand select, immediate, rd, legality and latency class.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  ctrl,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic        illegal,
    output lat_class_t  lat_class
);

    logic [6:0] opcode_s;
    logic [6:0] f7_s;
    logic [2:0] f3_s;
    logic       fmt_illegal_s;
    logic       slt_s;

    assign opcode_s = inst[6:0];
    assign f7_s     = inst[31:25];
    assign f3_s     = inst[14:12];
    assign rd       = inst[11:7];
    assign imm      = {{20{inst[31]}}, inst[31:20]};

    // Field checks per format; the ALU has no slt/sltu, so those encodings are rejected after
    always_comb begin
        ctrl          = 5'd0;
        use_imm       = 1'b0;
        fmt_illegal_s = 1'b1;
        case (opcode_s)
            OP_R: begin
                ctrl = {f7_s[5], f7_s[0], f3_s};
                case (f7_s)
                    7'b0000000, 7'b0000001: fmt_illegal_s = 1'b0;
                    7'b0100000: fmt_illegal_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
                    default:    fmt_illegal_s = 1'b1;
                endcase
            end
            OP_I: begin
                use_imm = 1'b1;
                ctrl    = {((f3_s == 3'b101) ? inst[30] : 1'b0), 1'b0, f3_s};
                case (f3_s)
                    3'b001:  fmt_illegal_s = (f7_s != 7'b0000000);
                    3'b101:  fmt_illegal_s = !((f7_s == 7'b0000000) || (f7_s == 7'b0100000));
                    default: fmt_illegal_s = 1'b0;
                endcase
            end
            default: begin
                ctrl          = 5'd0;
                fmt_illegal_s = 1'b1;
            end
        endcase
    end

    assign slt_s     = !ctrl[3] && ((f3_s == 3'b010) || (f3_s == 3'b011));
    assign illegal   = fmt_illegal_s | slt_s;
    assign lat_class = lat_class_sel(ctrl);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer in front of a multi-cycle ALU: decode, hold operands for the op latency, capture, hand off.
// Optional build macro ALU_ISSUE_PERF_EN adds retired-op and stall counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int LAT_I = 1,
    parameter int LAT_M = 2,
    parameter int LAT_D = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_y,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_cout,
    output logic [4:0]  out_rd,
    output logic        out_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);

    localparam int LAT_MAX = (LAT_D > LAT_M) ? ((LAT_D > LAT_I) ? LAT_D : LAT_I)
                                             : ((LAT_M > LAT_I) ? LAT_M : LAT_I);
    localparam int CW = $clog2(LAT_MAX + 1);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] lat_load_s;

    logic [4:0]   dec_ctrl_s;
    logic         dec_use_imm_s;
    logic [31:0]  dec_imm_s;
    logic [4:0]   dec_rd_s;
    logic         dec_illegal_s;
    lat_class_t   dec_lat_class_s;

    logic [31:0]  alu_a_r;
    logic [31:0]  alu_b_r;
    logic [4:0]   alu_ctrl_r;
    logic [31:0]  out_result_r;
    logic         out_cout_r;
    logic [4:0]   out_rd_r;
    logic         out_illegal_r;
    logic         accept_s;
    logic         retire_s;

    alu_ctrl_decode u_decode (
        .inst      (in_inst),
        .ctrl      (dec_ctrl_s),
        .use_imm   (dec_use_imm_s),
        .imm       (dec_imm_s),
        .rd        (dec_rd_s),
        .illegal   (dec_illegal_s),
        .lat_class (dec_lat_class_s)
    );

    // Latency to load at accept; the counter then runs down to zero before the capture edge
    always_comb begin
        case (dec_lat_class_s)
            LAT_CLASS_I: lat_load_s = CW'(LAT_I);
            LAT_CLASS_M: lat_load_s = CW'(LAT_M);
            LAT_CLASS_D: lat_load_s = CW'(LAT_D);
            default:     lat_load_s = CW'(LAT_I);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = dec_illegal_s ? ST_DONE : ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags are pure state decodes of the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: in_ready  = 1'b1;
            ST_EXEC: in_ready  = 1'b0;
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    assign accept_s = (state_r == ST_IDLE) && in_valid;
    assign retire_s = (state_r == ST_DONE) && out_ready;

    // Operand/ctrl hold registers, latency counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= '0;
            alu_a_r       <= 32'd0;
            alu_b_r       <= 32'd0;
            alu_ctrl_r    <= 5'd0;
            out_result_r  <= 32'd0;
            out_cout_r    <= 1'b0;
            out_rd_r      <= 5'd0;
            out_illegal_r <= 1'b0;
        end else if (accept_s) begin
            out_rd_r      <= dec_rd_s;
            out_illegal_r <= dec_illegal_s;
            if (dec_illegal_s) begin
                out_result_r <= 32'd0;
                out_cout_r   <= 1'b0;
            end else begin
                alu_a_r    <= in_rs1;
                alu_b_r    <= dec_use_imm_s ? dec_imm_s : in_rs2;
                alu_ctrl_r <= dec_ctrl_s;
                cnt_r      <= lat_load_s;
            end
        end else if (state_r == ST_EXEC) begin
            if (cnt_r == '0) begin
                out_result_r <= alu_y;
                out_cout_r   <= alu_cout;
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_ctrl    = alu_ctrl_r;
    assign out_result  = out_result_r;
    assign out_cout    = out_cout_r;
    assign out_rd      = out_rd_r;
    assign out_illegal = out_illegal_r;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops_r;
    logic [31:0] perf_stall_r;

    // Retired legal ops and back-pressure cycles, both wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_r   <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (retire_s && !out_illegal_r) begin
                perf_ops_r <= perf_ops_r + 32'd1;
            end else begin
                perf_ops_r <= perf_ops_r;
            end
            if ((state_r == ST_DONE) && !out_ready) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_ops   = perf_ops_r;
    assign perf_stall = perf_stall_r;
`else
    logic unused_s;
    assign unused_s = retire_s;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and issue model.
module tb_alu_issue_ctrl;

    localparam int LAT_I = 1;
    localparam int LAT_M = 2;
    localparam int LAT_D = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_y;
    logic        alu_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_cout;
    logic [4:0]  out_rd;
    logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
    logic [31:0] exp_ops = 32'd0;
    logic [31:0] exp_stall = 32'd0;
`endif

    int total_cnt = 0;
    int bad_cnt = 0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_b = 32'd0;
    logic [4:0]  last_ctrl = 5'd0;

    alu_issue_ctrl #(.LAT_I(LAT_I), .LAT_M(LAT_M), .LAT_D(LAT_D)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_cout    (out_cout),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Legality and ctrl code by instruction class, straight from the mnemonic table
    task automatic ref_decode(input logic [31:0] inst, output logic legal, output logic [4:0] ctrl);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = inst[6:0];
        f7 = inst[31:25];
        f3 = inst[14:12];
        legal = 1'b0;
        ctrl  = 5'd0;
        if (op == 7'b0110011) begin
            if (f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) begin
                legal = 1'b1; ctrl = {2'b00, f3};
            end else if (f7 == 7'h01) begin
                legal = 1'b1; ctrl = 5'd8 + {2'b00, f3};
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                legal = 1'b1; ctrl = 5'd16;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                legal = 1'b1; ctrl = 5'd21;
            end
        end else if (op == 7'b0010011) begin
            if (f3 == 3'd1) begin
                legal = (f7 == 7'h00); ctrl = 5'd1;
            end else if (f3 == 3'd5) begin
                legal = (f7 == 7'h00) || (f7 == 7'h20);
                ctrl  = (f7 == 7'h20) ? 5'd21 : 5'd5;
            end else if (f3 != 3'd2 && f3 != 3'd3) begin
                legal = 1'b1; ctrl = {2'b00, f3};
            end
        end
    endtask

    function automatic int ref_lat(input logic [4:0] c);
        if (c >= 5'd8 && c < 5'd12) return LAT_M;
        if (c >= 5'd12 && c < 5'd16) return LAT_D;
        return LAT_I;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            5'd0:  return a + b;
            5'd16: return a - b;
            5'd1:  return a << b[4:0];
            5'd4:  return a ^ b;
            5'd5:  return a >> b[4:0];
            5'd21: return 32'($signed(a) >>> b[4:0]);
            5'd6:  return a | b;
            5'd7:  return a & b;
            5'd8:  begin p = ua * ub; return p[31:0]; end
            5'd9:  begin p = sa * sb; return p[63:32]; end
            5'd10: begin p = sa * $signed(ub); return p[63:32]; end
            5'd11: begin p = ua * ub; return p[63:32]; end
            5'd12: return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            5'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'd14: return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            5'd15: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'($urandom), 5'($urandom), f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'($urandom), f3, rd, 7'b0010011};
    endfunction

    // Issue one instruction from idle, drive the ALU model, stall the consumer, retire
    task automatic run_op(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2, input int stall);
        logic        legal;
        logic [4:0]  ctrl;
        logic [31:0] b;
        logic [31:0] y;
        logic [31:0] exp_res;
        logic        cy;
        logic        exp_cy;
        int          lat;
        int          w;
        ref_decode(inst, legal, ctrl);
        b   = (inst[6:0] == 7'b0010011) ? {{20{inst[31]}}, inst[31:20]} : rs2;
        y   = ref_alu(ctrl, rs1, b);
        cy  = 1'($urandom);
        lat = ref_lat(ctrl);
        w = 0;
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_rs1    = rs1;
        in_rs2    = rs2;
        out_ready = (stall == 0);
        alu_y     = $urandom;
        alu_cout  = ~cy;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_inst  = $urandom;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        if (legal) begin
            for (int k = 1; k <= lat + 1; k++) begin
                check("exec_out_valid", {31'd0, out_valid}, 32'd0);
                check("exec_in_ready", {31'd0, in_ready}, 32'd0);
                check("exec_alu_a", alu_a, rs1);
                check("exec_alu_b", alu_b, b);
                check("exec_alu_ctrl", {27'd0, alu_ctrl}, {27'd0, ctrl});
                alu_y    = (k == lat + 1) ? y : $urandom;
                alu_cout = (k == lat + 1) ? cy : ~cy;
                @(posedge clk);
                @(negedge clk);
            end
            alu_y     = $urandom;
            alu_cout  = ~cy;
            last_a    = rs1;
            last_b    = b;
            last_ctrl = ctrl;
            exp_res   = y;
            exp_cy    = cy;
        end else begin
            exp_res = 32'd0;
            exp_cy  = 1'b0;
        end
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("done_out_valid", {31'd0, out_valid}, 32'd1);
            check("done_in_ready", {31'd0, in_ready}, 32'd0);
            check("done_illegal", {31'd0, out_illegal}, {31'd0, ~legal});
            check("done_result", out_result, exp_res);
            check("done_cout", {31'd0, out_cout}, {31'd0, exp_cy});
            check("done_rd", {27'd0, out_rd}, {27'd0, inst[11:7]});
            check("done_alu_a", alu_a, last_a);
            check("done_alu_b", alu_b, last_b);
            check("done_alu_ctrl", {27'd0, alu_ctrl}, {27'd0, last_ctrl});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("retire_out_valid", {31'd0, out_valid}, 32'd0);
        check("retire_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        if (legal) exp_ops = exp_ops + 32'd1;
        exp_stall = exp_stall + 32'(stall);
        check("perf_ops", perf_ops, exp_ops);
        check("perf_stall", perf_stall, exp_stall);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_ctrl"}, {27'd0, alu_ctrl}, 32'd0);
        check({tag, "_result"}, out_result, 32'd0);
        check({tag, "_cout"}, {31'd0, out_cout}, 32'd0);
        check({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
        check({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        check({tag, "_perf_ops"}, perf_ops, 32'd0);
        check({tag, "_perf_stall"}, perf_stall, 32'd0);
        exp_ops   = 32'd0;
        exp_stall = 32'd0;
`endif
        last_a    = 32'd0;
        last_b    = 32'd0;
        last_ctrl = 5'd0;
    endtask

    initial begin
        logic [31:0] inst;
        logic [6:0]  f7;
        logic [2:0]  f3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_rs1    = 32'd0;
        in_rs2    = 32'd0;
        alu_y     = 32'd0;
        alu_cout  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'd5, 32'd7, 0);
        run_op(mk_r(7'h20, 3'd0, 5'd4), 32'd3, 32'd5, 0);
        run_op(mk_i(12'h404, 3'd5, 5'd6), 32'h8000_0000, 32'd0, 0);
        run_op(mk_r(7'h01, 3'd4, 5'd7), 32'd100, 32'd7, 1);
        run_op(mk_i(12'h005, 3'd2, 5'd8), 32'd9, 32'd9, 0);
        run_op({25'h1ABCDE, 7'b0000011}, 32'd1, 32'd2, 0);
        run_op(mk_r(7'h00, 3'd7, 5'd9), 32'hF0F0_1234, 32'h0FF0_FF00, 5);

        // Reset in the middle of a multiply, then a normal add
        in_valid  = 1'b1;
        in_inst   = mk_r(7'h01, 3'd0, 5'd5);
        in_rs1    = 32'd6;
        in_rs2    = 32'd7;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(mk_r(7'h00, 3'd0, 5'd10), 32'd40, 32'd2, 0);

        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    case ($urandom_range(0, 3))
                        0: f7 = 7'h00;
                        1: f7 = 7'h01;
                        2: f7 = 7'h20;
                        default: f7 = 7'($urandom);
                    endcase
                    inst = mk_r(f7, f3, 5'($urandom));
                end
                1: begin
                    inst = mk_i(12'($urandom), f3, 5'($urandom));
                    if ($urandom_range(0, 1) == 0) inst[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
                end
                2: inst = mk_r(7'h01, f3, 5'($urandom));
                default: inst = $urandom;
            endcase
            run_op(inst, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
